// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   This is the responder end of the memory-control word. It accepts one
//   decoded memory micro-op per handshake and drives the data-memory bus.
//   It formats the byte enables and the lane-shifted store data, and waits for
//   the single-cycle memory response. For loads it then aligns and zero- or
//   sign-extends the returned data and issues a one-cycle writeback.
//   Misaligned loads and stores are rejected with a one-cycle misalign pulse.
//
// Configuration:
//   MEM_ACC_TIMEOUT_EN : when defined, a watchdog aborts an ACCESS phase that
//                        receives no response within TIMEOUT_CYCLES cycles and
//                        pulses `timeout`. When undefined, ACCESS waits
//                        indefinitely and `timeout` is constant 0.
//
// Parameters:
//   XLEN           : data/address width (only 32 is supported)
//   TIMEOUT_CYCLES : watchdog limit, meaningful only with MEM_ACC_TIMEOUT_EN
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake (ready only while IDLE)
//   req_memfn, req_memsz      : function (nm/st/ld) and size (b/h/w)
//   req_ldext                 : 0 = zero-extend, 1 = sign-extend loads
//   req_addr, req_wdata       : effective byte address, unshifted store data
//   req_rd                    : load destination register
//   dmem_read / dmem_write    : bus strobes, held until dmem_resp
//   dmem_address              : word-aligned bus address
//   dmem_wdata, dmem_mbe      : lane-shifted store data, byte enables
//   dmem_resp, dmem_rdata     : one-cycle completion and read data
//   wb_valid, wb_rd, wb_data  : one-cycle load writeback
//   misalign                  : one-cycle pulse for a rejected access
//   timeout                   : one-cycle watchdog pulse (0 unless enabled)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_memfn,
    input  logic [1:0]      req_memsz,
    input  logic            req_ldext,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_address,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_mbe,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign,
    output logic            timeout
);

    // Elaboration-time guard: only a 32-bit datapath and a non-zero limit make sense
    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("mem_access_unit: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    localparam logic [1:0] FN_ST = 2'b01;
    localparam logic [1:0] FN_LD = 2'b10;

    // Byte enables for a size at a byte offset; size 3 behaves as a word
    function automatic logic [3:0] calc_mbe(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] mbe;
        case (sz)
            2'd0:    mbe = 4'b0001 << off;
            2'd1:    mbe = 4'b0011 << off;
            default: mbe = 4'b1111;
        endcase
        return mbe;
    endfunction

    // Accesses must be naturally aligned; bytes are always aligned
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Move the addressed lane to bit 0, truncate to the access size, then extend
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] rdata,
                                                 input logic [1:0]      sz,
                                                 input logic            ext,
                                                 input logic [1:0]      off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = rdata >> {off, 3'b000};
        case (sz)
            2'd0:    res = ext ? {{(XLEN-8){sh[7]}}, sh[7:0]}
                               : {{(XLEN-8){1'b0}}, sh[7:0]};
            2'd1:    res = ext ? {{(XLEN-16){sh[15]}}, sh[15:0]}
                               : {{(XLEN-16){1'b0}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            ld_q, ld_d;
    logic [1:0]      sz_q, sz_d;
    logic            ext_q, ext_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      mbe_q, mbe_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            rd_strb_q, rd_strb_d;
    logic            wr_strb_q, wr_strb_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            misalign_q, misalign_d;

    logic            req_is_ld_s;
    logic            req_is_st_s;
    logic [1:0]      req_off_s;
    logic            tmo_hit_s;

    assign req_is_ld_s = (req_memfn == FN_LD);
    assign req_is_st_s = (req_memfn == FN_ST);
    assign req_off_s   = req_addr[1:0];

`ifdef MEM_ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // The counter holds the number of response-less ACCESS cycles already
    // completed, so the limit is reached in the TIMEOUT_CYCLES-th ACCESS cycle.
    assign tmo_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;
`else
    assign tmo_hit_s = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state and next-output logic of the access FSM
    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        sz_d       = sz_q;
        ext_d      = ext_q;
        off_d      = off_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        mbe_d      = mbe_q;
        wdata_d    = wdata_q;
        rd_strb_d  = rd_strb_q;
        wr_strb_d  = wr_strb_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
`ifdef MEM_ACC_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q && (req_is_ld_s || req_is_st_s)) begin
                    if (is_misaligned(req_memsz, req_off_s)) begin
                        misalign_d = 1'b1;
                    end else begin
                        ld_d      = req_is_ld_s;
                        sz_d      = req_memsz;
                        ext_d     = req_ldext;
                        off_d     = req_off_s;
                        rd_d      = req_rd;
                        addr_d    = {req_addr[XLEN-1:2], 2'b00};
                        mbe_d     = calc_mbe(req_memsz, req_off_s);
                        wdata_d   = req_wdata << {req_off_s, 3'b000};
                        rd_strb_d = req_is_ld_s;
                        wr_strb_d = req_is_st_s;
                        state_d   = ST_ACCESS;
`ifdef MEM_ACC_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end else begin
                    // nm ops (including fn 2'b11) and idle cycles leave no trace
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // A response in the limit cycle still completes normally
                if (dmem_resp) begin
                    rd_strb_d = 1'b0;
                    wr_strb_d = 1'b0;
                    if (ld_q) begin
                        wb_data_d = fmt_load(dmem_rdata, sz_q, ext_q, off_q);
                        state_d   = ST_WB;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    rd_strb_d = 1'b0;
                    wr_strb_d = 1'b0;
                    state_d   = ST_IDLE;
`ifdef MEM_ACC_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else begin
`ifdef MEM_ACC_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                    state_d = ST_ACCESS;
                end
            end

            ST_WB: begin
                // x0 is never written, but wb_data was already refreshed
                wb_valid_d = (rd_q != 5'd0);
                wb_rd_d    = rd_q;
                state_d    = ST_IDLE;
            end

            default: begin
                rd_strb_d = 1'b0;
                wr_strb_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            ld_q       <= 1'b0;
            sz_q       <= 2'd0;
            ext_q      <= 1'b0;
            off_q      <= 2'd0;
            rd_q       <= 5'd0;
            addr_q     <= '0;
            mbe_q      <= 4'd0;
            wdata_q    <= '0;
            rd_strb_q  <= 1'b0;
            wr_strb_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            ld_q       <= ld_d;
            sz_q       <= sz_d;
            ext_q      <= ext_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            mbe_q      <= mbe_d;
            wdata_q    <= wdata_d;
            rd_strb_q  <= rd_strb_d;
            wr_strb_q  <= wr_strb_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef MEM_ACC_TIMEOUT_EN
    // Watchdog counter and timeout pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign req_ready    = ready_q;
    assign dmem_read    = rd_strb_q;
    assign dmem_write   = wr_strb_q;
    assign dmem_address = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_mbe     = mbe_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. It applies a table of directed
// vectors, a few hand-written multi-cycle sequences (reset mid-access, a stray
// response, and the watchdog when MEM_ACC_TIMEOUT_EN is defined), and then
// randomized transactions. Expected values come from a transaction-level
// model that works on byte counts and plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

`ifdef MEM_ACC_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_memfn;
    logic [1:0]  req_memsz;
    logic        req_ldext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic        timeout;

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_memfn(req_memfn), .req_memsz(req_memsz), .req_ldext(req_ldext),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fn;
        logic [1:0]  sz;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          nwait;
        logic [3:0]  mbe;
        logic [31:0] dwdata;
        logic [31:0] wbdata;
        logic        mis;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] fn, input logic [1:0] sz, input logic ext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [4:0] rd, input int nwait,
                                input logic [3:0] mbe, input logic [31:0] dwdata,
                                input logic [31:0] wbdata, input logic mis);
        vec_t v;
        v.fn = fn; v.sz = sz; v.ext = ext; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.rd = rd; v.nwait = nwait; v.mbe = mbe;
        v.dwdata = dwdata; v.wbdata = wbdata; v.mis = mis;
        return v;
    endfunction

    // Reference model: byte count of the access, lanes by arithmetic
    function automatic vec_t model(input logic [1:0] fn, input logic [1:0] sz, input logic ext,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input logic [4:0] rd, input int nwait);
        vec_t v;
        int n;
        int off;
        longint unsigned val;
        longint unsigned span;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 32'd4);
        v = mk(fn, sz, ext, addr, wdata, rdata, rd, nwait, 4'd0, 32'd0, 32'd0, 1'b0);
        v.mis    = (fn == 2'b01 || fn == 2'b10) && ((off % n) != 0);
        v.mbe    = 4'(((64'd1 << n) - 64'd1) << off);
        v.dwdata = 32'(64'(wdata) << (8 * off));
        span     = 64'd1 << (8 * n);
        val      = (64'(rdata) >> (8 * off)) % span;
        if (ext && n < 4 && val >= span / 64'd2)
            val = val + 64'h1_0000_0000 - span;
        v.wbdata = val[31:0];
        return v;
    endfunction

    // Drive one request and follow it to completion, checking every cycle
    task automatic run_txn(input vec_t v, input string tag);
        logic is_ld;
        logic is_st;
        is_ld = (v.fn == 2'b10);
        is_st = (v.fn == 2'b01);
        chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_memfn = v.fn;
        req_memsz = v.sz;
        req_ldext = v.ext;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!(is_ld || is_st)) begin
            chk({tag, "_nm_read"}, 32'(dmem_read), 32'd0);
            chk({tag, "_nm_write"}, 32'(dmem_write), 32'd0);
            chk({tag, "_nm_misalign"}, 32'(misalign), 32'd0);
            chk({tag, "_nm_ready"}, 32'(req_ready), 32'd1);
            return;
        end
        if (v.mis) begin
            chk({tag, "_mis_pulse"}, 32'(misalign), 32'd1);
            chk({tag, "_mis_read"}, 32'(dmem_read), 32'd0);
            chk({tag, "_mis_write"}, 32'(dmem_write), 32'd0);
            chk({tag, "_mis_ready"}, 32'(req_ready), 32'd1);
            step();
            chk({tag, "_mis_drop"}, 32'(misalign), 32'd0);
            chk({tag, "_mis_read2"}, 32'(dmem_read), 32'd0);
            return;
        end
        chk({tag, "_no_misalign"}, 32'(misalign), 32'd0);
        for (int i = 0; i <= v.nwait; i++) begin
            chk({tag, "_read"}, 32'(dmem_read), 32'(is_ld));
            chk({tag, "_write"}, 32'(dmem_write), 32'(is_st));
            chk({tag, "_address"}, dmem_address, v.addr & 32'hFFFF_FFFC);
            chk({tag, "_mbe"}, 32'(dmem_mbe), 32'(v.mbe));
            if (is_st) chk({tag, "_wdata"}, dmem_wdata, v.dwdata);
            chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
            chk({tag, "_wb_quiet"}, 32'(wb_valid), 32'd0);
            dmem_resp  = (i == v.nwait);
            dmem_rdata = (i == v.nwait) ? v.rdata : 32'($urandom);
            step();
        end
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
        chk({tag, "_read_off"}, 32'(dmem_read), 32'd0);
        chk({tag, "_write_off"}, 32'(dmem_write), 32'd0);
        chk({tag, "_no_timeout"}, 32'(timeout), 32'd0);
        if (is_st) begin
            chk({tag, "_st_ready"}, 32'(req_ready), 32'd1);
            chk({tag, "_st_no_wb"}, 32'(wb_valid), 32'd0);
            return;
        end
        chk({tag, "_wbstate_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_wbstate_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbstate_data"}, wb_data, v.wbdata);
        step();
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(v.rd != 5'd0));
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({tag, "_wb_data"}, wb_data, v.wbdata);
        chk({tag, "_ld_ready"}, 32'(req_ready), 32'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_memfn  = 2'b00;
        req_memsz  = 2'd0;
        req_ldext  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;

        //             fn     sz    ext   addr          wdata         rdata         rd    nw  mbe      dwdata        wbdata        mis
        tbl[0]  = mk(2'b10, 2'd0, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h80FF_0000, 5'd5, 0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b0);
        tbl[1]  = mk(2'b10, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_0000, 32'hBEEF_1234, 5'd7, 4, 4'b1100, 32'h0000_0000, 32'h0000_BEEF, 1'b0);
        tbl[2]  = mk(2'b01, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0000_0000, 5'd0, 0, 4'b0010, 32'h0000_AB00, 32'h0000_0000, 1'b0);
        tbl[3]  = mk(2'b01, 2'd2, 1'b0, 32'h0000_4002, 32'h1111_2222, 32'h0000_0000, 5'd0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        tbl[4]  = mk(2'b10, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 5'd0, 1, 4'b1111, 32'h0000_0000, 32'h1234_5678, 1'b0);
        tbl[5]  = mk(2'b10, 2'd1, 1'b1, 32'h0000_0002, 32'h0000_0000, 32'h8001_0000, 5'd3, 2, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b0);
        tbl[6]  = mk(2'b00, 2'd2, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 5'd1, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        tbl[7]  = mk(2'b11, 2'd2, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 5'd2, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        tbl[8]  = mk(2'b10, 2'd3, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'hCAFE_BABE, 5'd9, 0, 4'b1111, 32'h0000_0000, 32'hCAFE_BABE, 1'b0);
        tbl[9]  = mk(2'b10, 2'd1, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 5'd4, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        tbl[10] = mk(2'b01, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0000_0000, 5'd0, 3, 4'b1100, 32'hABCD_0000, 32'h0000_0000, 1'b0);
        tbl[11] = mk(2'b10, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_9900, 5'd8, 0, 4'b0010, 32'h0000_0000, 32'h0000_0099, 1'b0);

        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_read", 32'(dmem_read), 32'd0);
        chk("rst_write", 32'(dmem_write), 32'd0);
        chk("rst_address", dmem_address, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_mbe", 32'(dmem_mbe), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // A stray response while IDLE must not start anything
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_resp = 1'b0;
        chk("stray_read", 32'(dmem_read), 32'd0);
        chk("stray_ready", 32'(req_ready), 32'd1);
        step();
        chk("stray_wb", 32'(wb_valid), 32'd0);

        // Reset in the middle of a load, then a late response
        req_valid = 1'b1; req_memfn = 2'b10; req_memsz = 2'd2; req_ldext = 1'b0;
        req_addr = 32'h0000_0010; req_rd = 5'd4;
        step();
        req_valid = 1'b0;
        chk("rstmid_read_on", 32'(dmem_read), 32'd1);
        step();
        chk("rstmid_read_held", 32'(dmem_read), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        chk("rstmid_read_off", 32'(dmem_read), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_wb0", 32'(wb_valid), 32'd0);
        step();
        dmem_resp = 1'b0;
        chk("rstmid_late_read", 32'(dmem_read), 32'd0);
        chk("rstmid_late_wb", 32'(wb_valid), 32'd0);
        step();
        chk("rstmid_late_wb2", 32'(wb_valid), 32'd0);
        chk("rstmid_late_ready", 32'(req_ready), 32'd1);

`ifdef MEM_ACC_TIMEOUT_EN
        // Load with no response: watchdog fires after TMO ACCESS cycles
        req_valid = 1'b1; req_memfn = 2'b10; req_memsz = 2'd2; req_ldext = 1'b0;
        req_addr = 32'h0000_0020; req_rd = 5'd6;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_read_held", 32'(dmem_read), 32'd1);
            chk("tmo_not_yet", 32'(timeout), 32'd0);
            step();
        end
        chk("tmo_pulse", 32'(timeout), 32'd1);
        chk("tmo_read_off", 32'(dmem_read), 32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd1);
        chk("tmo_no_wb", 32'(wb_valid), 32'd0);
        step();
        chk("tmo_pulse_end", 32'(timeout), 32'd0);
        chk("tmo_no_wb2", 32'(wb_valid), 32'd0);
        // Response in the limit cycle wins
        run_txn(model(2'b10, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_F00D, 5'd6, TMO - 1), "tmo_edge");
`else
        // Without the watchdog a long wait completes normally
        run_txn(model(2'b10, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_F00D, 5'd6, 20), "long_wait");
`endif

        // Randomized back-to-back transactions
        for (int i = 0; i < 200; i++) begin
            rv = model(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'($urandom), 32'($urandom), 32'($urandom), 5'($urandom_range(0, 31)),
                       int'($urandom_range(0, 5)));
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
